// File: rtl/robs_mult_arbiter_if.sv
// Requester and multiplier-side signal bundle for robs_mult_arbiter.
// slave = arbiter view, master = requesters plus the shared multiplier.
interface robs_mult_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [2*WIDTH-1:0]    result;
   logic                  err;
   logic                  mult_reset;
   logic [WIDTH-1:0]      mult_x;
   logic [WIDTH-1:0]      mult_y;
   logic                  mult_done;
   logic [2*WIDTH-1:0]    mult_product;

   modport slave (
      input  req, a_in, b_in, mult_done, mult_product,
      output gnt, ack, result, err, mult_reset, mult_x, mult_y
   );

   modport master (
      output req, a_in, b_in, mult_done, mult_product,
      input  gnt, ack, result, err, mult_reset, mult_x, mult_y
   );
endinterface

// File: rtl/robs_mult_arbiter.sv
// Round-robin sequencer sharing one Robertson's multiplier: grant, 1-cycle LAUNCH reset, wait done, 1-cycle RESP ack.
// Requesters hold req until ack; ROBS_ARB_TIMEOUT_EN adds a BUSY watchdog that acks with err and result=0.
module robs_mult_arbiter #(
   parameter int NREQ    = 4,
`ifdef ROBS_ARB_TIMEOUT_EN
   parameter int TIMEOUT = 64,
`endif
   parameter int WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   robs_mult_arbiter_if.slave   bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_BUSY   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic [PW-1:0]       gnt_idx_q, gnt_idx_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [WIDTH-1:0]    mx_q, mx_d;
   logic [WIDTH-1:0]    my_q, my_d;
   logic [2*WIDTH-1:0]  result_q, result_d;
   logic                err_q, err_d;

   logic                sel_vld;
   logic [PW-1:0]       sel_idx;
   int                  scan_k;
   logic                tmo_hit;
   logic [NREQ-1:0]     still_req;

   assign still_req = gnt_q & bus.req;

   // First requesting slot at or after ptr, wrapping past NREQ-1.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      scan_k  = 0;
      for (int i = 0; i < NREQ; i++) begin
         scan_k = int'(ptr_q) + i;
         if (scan_k >= NREQ) scan_k = scan_k - NREQ;
         if (!sel_vld && bus.req[PW'(scan_k)]) begin
            sel_vld = 1'b1;
            sel_idx = PW'(scan_k);
         end
      end
   end

`ifdef ROBS_ARB_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      tmo_hit   = 1'b0;
      if (state_q == ST_LAUNCH) begin
         tmo_cnt_d = '0;
      end else if (state_q == ST_BUSY) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
         tmo_hit   = (tmo_cnt_d == TW'(TIMEOUT));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tmo_cnt_q <= '0;
      else       tmo_cnt_q <= tmo_cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      mx_d      = mx_q;
      my_d      = my_q;
      result_d  = result_q;
      ack_d     = '0;
      err_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (sel_vld) begin
               gnt_d          = '0;
               gnt_d[sel_idx] = 1'b1;
               gnt_idx_d      = sel_idx;
               mx_d           = bus.a_in[sel_idx*WIDTH +: WIDTH];
               my_d           = bus.b_in[sel_idx*WIDTH +: WIDTH];
               state_d        = ST_LAUNCH;
            end
         end
         ST_LAUNCH: state_d = ST_BUSY;
         ST_BUSY: begin
            // A done on the same edge as the watchdog wins.
            if (bus.mult_done) begin
               result_d = bus.mult_product;
               ack_d    = still_req;
               state_d  = ST_RESP;
            end else if (tmo_hit) begin
               result_d = '0;
               ack_d    = still_req;
               err_d    = |still_req;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
            if (NREQ == 1 || gnt_idx_q == PW'(NREQ - 1)) ptr_d = '0;
            else                                        ptr_d = gnt_idx_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         ack_q     <= '0;
         gnt_idx_q <= '0;
         ptr_q     <= '0;
         mx_q      <= '0;
         my_q      <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
         mx_q      <= mx_d;
         my_q      <= my_d;
         result_q  <= result_d;
         err_q     <= err_d;
      end
   end

   // Combinational so the multiplier is also held in reset with the arbiter.
   assign bus.mult_reset = reset | (state_q == ST_LAUNCH);
   assign bus.gnt        = gnt_q;
   assign bus.ack        = ack_q;
   assign bus.result     = result_q;
   assign bus.err        = err_q;
   assign bus.mult_x     = mx_q;
   assign bus.mult_y     = my_q;

`ifndef SYNTHESIS
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
   a_gnt_idle:    assert property (@(posedge clk) disable iff (reset)
                                   (state_q == ST_IDLE) |-> (gnt_q == '0));
   a_gnt_active:  assert property (@(posedge clk) disable iff (reset)
                                   (state_q != ST_IDLE) |-> $onehot(gnt_q));
   a_ack_resp:    assert property (@(posedge clk) disable iff (reset)
                                   (ack_q != '0) |-> (state_q == ST_RESP));
   a_ack_in_gnt:  assert property (@(posedge clk) disable iff (reset)
                                   ((ack_q & ~gnt_q) == '0));
`endif

endmodule

// File: tb/tb_robs_mult_arbiter.sv
// Directed bench for robs_mult_arbiter with a fixed-latency signed multiplier model.
// Timeout case runs only when ROBS_ARB_TIMEOUT_EN is defined.
module tb_robs_mult_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int MLAT  = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   robs_mult_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   robs_mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Multiplier stand-in: done latches MLAT edges after its reset drops.
   logic        mdl_hang = 1'b0;
   logic [1:0]  mdl_cnt  = '0;
   logic        mdl_done = 1'b0;
   logic [15:0] mdl_prod = '0;

   always @(posedge clk) begin
      if (bus.mult_reset) begin
         mdl_cnt  <= '0;
         mdl_done <= 1'b0;
      end else if (!mdl_hang && !mdl_done) begin
         if (mdl_cnt == 2'(MLAT - 1)) begin
            mdl_done <= 1'b1;
            mdl_prod <= $signed(bus.mult_x) * $signed(bus.mult_y);
         end else begin
            mdl_cnt <= mdl_cnt + 1'b1;
         end
      end
   end

   assign bus.mult_done    = mdl_done;
   assign bus.mult_product = mdl_prod;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
      bus.a_in[idx*WIDTH +: WIDTH] = a;
      bus.b_in[idx*WIDTH +: WIDTH] = b;
   endtask

   // Follows one operation from grant to the IDLE cycle after RESP.
   // ewait = granted cycles after LAUNCH with ack low; drop_at drops req at that cycle.
   task automatic expect_op(input string tag, input int idx, input logic [7:0] ex, input logic [7:0] ey,
                            input logic [15:0] eres, input bit eack, input bit eerr,
                            input int ewait, input int drop_at);
      bit          seen_g = 1'b0;
      bit          fin    = 1'b0;
      int          waitc  = 0;
      int          nack   = 0;
      int          multi  = 0;
      int          pulses = 0;
      logic [3:0]  ackv   = '0;
      logic [15:0] resv   = '0;
      logic        errv   = 1'b0;
      for (int t = 0; t < 10 && !seen_g; t++) begin
         @(negedge clk);
         if (bus.gnt != '0) seen_g = 1'b1;
      end
      check_val({tag, "_gnt_seen"}, 32'(seen_g), 32'd1);
      check_val({tag, "_gnt"}, 32'(bus.gnt), 32'(1 << idx));
      check_val({tag, "_launch"}, 32'(bus.mult_reset), 32'd1);
      check_val({tag, "_x"}, 32'(bus.mult_x), 32'(ex));
      check_val({tag, "_y"}, 32'(bus.mult_y), 32'(ey));
      for (int t = 0; t < 200 && !fin; t++) begin
         @(negedge clk);
         if (bus.mult_reset) pulses++;
         if (bus.ack != '0) begin
            nack++;
            ackv = bus.ack;
            resv = bus.result;
            errv = bus.err;
            if (!$onehot(bus.ack)) multi++;
         end else if (nack == 0 && bus.gnt != '0) begin
            waitc++;
         end
         if (bus.gnt == '0) fin = 1'b1;
         if (t == drop_at) bus.req[idx] = 1'b0;
      end
      check_val({tag, "_finished"}, 32'(fin), 32'd1);
      check_val({tag, "_extra_pulse"}, 32'(pulses), 32'd0);
      check_val({tag, "_wait_cycles"}, 32'(waitc), 32'(ewait));
      check_val({tag, "_ack_count"}, 32'(nack), eack ? 32'd1 : 32'd0);
      check_val({tag, "_ack_onehot"}, 32'(multi), 32'd0);
      check_val({tag, "_ack"}, 32'(ackv), eack ? 32'(1 << idx) : 32'd0);
      if (eack) begin
         check_val({tag, "_result"}, 32'(resv), 32'(eres));
         check_val({tag, "_err"}, 32'(errv), 32'(eerr));
         check_val({tag, "_result_held"}, 32'(bus.result), 32'(eres));
      end
   endtask

   initial begin
      bit got;
      reset    = 1'b1;
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;

      repeat (2) @(negedge clk);
      check_val("rst_gnt", 32'(bus.gnt), 32'd0);
      check_val("rst_ack", 32'(bus.ack), 32'd0);
      check_val("rst_result", 32'(bus.result), 32'd0);
      check_val("rst_err", 32'(bus.err), 32'd0);
      check_val("rst_x", 32'(bus.mult_x), 32'd0);
      check_val("rst_y", 32'(bus.mult_y), 32'd0);
      check_val("rst_mult_reset", 32'(bus.mult_reset), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check_val("idle_mult_reset", 32'(bus.mult_reset), 32'd0);

      // Single request: 7 * 6 = 42.
      set_ops(0, 8'd7, 8'd6);
      bus.req = 4'b0001;
      expect_op("single", 0, 8'd7, 8'd6, 16'd42, 1'b1, 1'b0, 4, -1);
      bus.req = 4'b0000;

      // Reset pointer back to 0 before the fairness sweep.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      set_ops(0, 8'd2,   8'd3);    // 6
      set_ops(1, 8'hFC,  8'd5);    // -4*5 = -20
      set_ops(2, 8'd9,   8'd10);   // 90
      set_ops(3, 8'hF9,  8'hF8);   // -7*-8 = 56
      bus.req = 4'b1111;
      expect_op("rr0",  0, 8'd2,  8'd3,  16'd6,    1'b1, 1'b0, 4, -1);
      expect_op("rr1",  1, 8'hFC, 8'd5,  16'hFFEC, 1'b1, 1'b0, 4, -1);
      expect_op("rr2",  2, 8'd9,  8'd10, 16'h005A, 1'b1, 1'b0, 4, -1);
      expect_op("rr3",  3, 8'hF9, 8'hF8, 16'h0038, 1'b1, 1'b0, 4, -1);
      expect_op("rr0b", 0, 8'd2,  8'd3,  16'd6,    1'b1, 1'b0, 4, -1);

      // Pointer now 1: requester 2 wins, then withdraws mid-BUSY.
      bus.req = 4'b1100;
      expect_op("wdraw", 2, 8'd9, 8'd10, 16'd0, 1'b0, 1'b0, 5, 1);
      expect_op("next3", 3, 8'hF9, 8'hF8, 16'h0038, 1'b1, 1'b0, 4, -1);
      bus.req = 4'b0000;

      // Reset while BUSY on a multiplier that never finishes.
      mdl_hang = 1'b1;
      bus.req  = 4'b0010;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
         @(negedge clk);
         if (bus.gnt != '0) got = 1'b1;
      end
      check_val("hang_gnt", 32'(bus.gnt), 32'b0010);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("midrst_gnt", 32'(bus.gnt), 32'd0);
      check_val("midrst_ack", 32'(bus.ack), 32'd0);
      check_val("midrst_result", 32'(bus.result), 32'd0);
      check_val("midrst_mult_reset", 32'(bus.mult_reset), 32'd1);
      @(negedge clk);
      reset    = 1'b0;
      mdl_hang = 1'b0;
      set_ops(2, 8'hFD, 8'd5);     // -3*5 = -15
      bus.req  = 4'b0100;
      expect_op("rst_rel", 2, 8'hFD, 8'd5, 16'hFFF1, 1'b1, 1'b0, 4, -1);
      bus.req  = 4'b0000;

`ifdef ROBS_ARB_TIMEOUT_EN
      mdl_hang = 1'b1;
      bus.req  = 4'b1000;
      expect_op("tmo", 3, 8'hF9, 8'hF8, 16'd0, 1'b1, 1'b1, 64, -1);
      bus.req  = 4'b0000;
      mdl_hang = 1'b0;
      @(negedge clk);
      check_val("tmo_idle_gnt", 32'(bus.gnt), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
